// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, ALU operation codes, immediate and result selectors.
// Used by decode_stage and imm_gen; the DECODE_TRAP_EN build adds no package content.
package decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    // IMM_Z yields a zero immediate for NOP decodes
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch -> decode -> execute handshake and ID/EX payload bundle.
// The illegal flag exists only when DECODE_TRAP_EN is defined.
interface decode_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     instr;
    logic [ADDR_WIDTH-1:0]     pc_in;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      RegWrite;
    logic [3:0]                ALUctrl;
    logic                      ALUSrc;
    logic [DATA_WIDTH-1:0]     ImmExt;
    logic                      MemWrite;
    logic [1:0]                ResultSrc;
    logic                      Branch;
    logic                      Jump;
    logic [2:0]                funct3;
    logic [ADDR_WIDTH-1:0]     pc_out;
`ifdef DECODE_TRAP_EN
    logic                      illegal;
`endif

    // master: surrounding pipeline (fetch + execute); slave: the decode stage
    modport master (
        output in_valid, instr, pc_in, flush, out_ready,
        input  in_ready, out_valid, rs1, rs2, rd, RegWrite, ALUctrl, ALUSrc, ImmExt,
               MemWrite, ResultSrc, Branch, Jump, funct3, pc_out
`ifdef DECODE_TRAP_EN
             , illegal
`endif
    );

    modport slave (
        input  in_valid, instr, pc_in, flush, out_ready,
        output in_ready, out_valid, rs1, rs2, rd, RegWrite, ALUctrl, ALUSrc, ImmExt,
               MemWrite, ResultSrc, Branch, Jump, funct3, pc_out
`ifdef DECODE_TRAP_EN
             , illegal
`endif
    );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator; sign bit instr[31] extended to DATA_WIDTH.
module imm_gen
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)(
    input  logic [31:7]           instr,
    input  imm_src_e              imm_src,
    output logic [DATA_WIDTH-1:0] imm_ext
);

    logic [31:0] imm;

    always_comb begin
        imm = '0;
        case (imm_src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign imm_ext = DATA_WIDTH'($signed(imm));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with ID/EX register, load-use bubble insertion and flush.
// Define DECODE_TRAP_EN to register an illegal-encoding flag alongside the payload.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
)(
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    logic        legal;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_used;
    logic        reg_write;
    logic        alu_src;
    logic        mem_write;
    logic        branch;
    logic        jump;
    alu_op_e     alu_op;
    result_src_e result_src;
    imm_src_e    imm_src;

    logic [REG_ADDR_WIDTH-1:0] dec_rs1;
    logic [REG_ADDR_WIDTH-1:0] dec_rs2;
    logic [REG_ADDR_WIDTH-1:0] dec_rd;
    logic [DATA_WIDTH-1:0]     imm_ext;
    logic [ADDR_WIDTH-1:0]     pc_d;
    logic                      hazard;
    logic                      accept;

    assign opcode = bus.instr[6:0];
    assign f3     = bus.instr[14:12];
    assign f7     = bus.instr[31:25];
    assign pc_d   = bus.pc_in;

    always_comb begin
        legal      = 1'b0;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        rd_used    = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op     = ALU_ADD;
        result_src = RES_ALU;
        imm_src    = IMM_Z;
        case (opcode)
            OP_LUI: begin
                legal = 1'b1; rd_used = 1'b1; reg_write = 1'b1;
                alu_op = ALU_PASSB; alu_src = 1'b1; imm_src = IMM_U;
            end
            OP_AUIPC: begin
                legal = 1'b1; rd_used = 1'b1; reg_write = 1'b1;
                alu_src = 1'b1; imm_src = IMM_U;
            end
            OP_JAL: begin
                legal = 1'b1; rd_used = 1'b1; reg_write = 1'b1;
                jump = 1'b1; result_src = RES_PC4; imm_src = IMM_J;
            end
            OP_JALR: begin
                legal = (f3 == 3'b000); rs1_used = 1'b1; rd_used = 1'b1; reg_write = 1'b1;
                jump = 1'b1; alu_src = 1'b1; result_src = RES_PC4; imm_src = IMM_I;
            end
            OP_BRANCH: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011);
                rs1_used = 1'b1; rs2_used = 1'b1;
                branch = 1'b1; alu_op = ALU_SUB; imm_src = IMM_B;
            end
            OP_LOAD: begin
                legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                rs1_used = 1'b1; rd_used = 1'b1; reg_write = 1'b1;
                alu_src = 1'b1; result_src = RES_MEM; imm_src = IMM_I;
            end
            OP_STORE: begin
                legal = f3 inside {3'b000, 3'b001, 3'b010};
                rs1_used = 1'b1; rs2_used = 1'b1;
                mem_write = 1'b1; alu_src = 1'b1; imm_src = IMM_S;
            end
            OP_IMM: begin
                // shift-immediates reuse the funct7 field and must encode it exactly
                if (f3 == 3'b001)
                    legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101)
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else
                    legal = 1'b1;
                rs1_used = 1'b1; rd_used = 1'b1; reg_write = 1'b1;
                alu_src = 1'b1; imm_src = IMM_I;
                alu_op = alu_from_funct3(f3, (f3 == 3'b101) && f7[5]);
            end
            OP_REG: begin
                legal = (f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                rs1_used = 1'b1; rs2_used = 1'b1; rd_used = 1'b1; reg_write = 1'b1;
                alu_op = alu_from_funct3(f3, f7[5]);
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            rs1_used   = 1'b0;
            rs2_used   = 1'b0;
            rd_used    = 1'b0;
            reg_write  = 1'b0;
            alu_src    = 1'b0;
            mem_write  = 1'b0;
            branch     = 1'b0;
            jump       = 1'b0;
            alu_op     = ALU_ADD;
            result_src = RES_ALU;
            imm_src    = IMM_Z;
        end
    end

    assign dec_rs1 = rs1_used ? REG_ADDR_WIDTH'(bus.instr[19:15]) : '0;
    assign dec_rs2 = rs2_used ? REG_ADDR_WIDTH'(bus.instr[24:20]) : '0;
    assign dec_rd  = rd_used  ? REG_ADDR_WIDTH'(bus.instr[11:7])  : '0;

    imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .instr   (bus.instr[31:7]),
        .imm_src (imm_src),
        .imm_ext (imm_ext)
    );

    // unused source fields are already zero, and rd!=0 keeps them from matching
    assign hazard = bus.in_valid && bus.out_valid && (bus.ResultSrc == RES_MEM) &&
                    (bus.rd != '0) && ((bus.rd == dec_rs1) || (bus.rd == dec_rs2));

    assign bus.in_ready = !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.rs1       <= '0;
            bus.rs2       <= '0;
            bus.rd        <= '0;
            bus.RegWrite  <= 1'b0;
            bus.ALUctrl   <= '0;
            bus.ALUSrc    <= 1'b0;
            bus.ImmExt    <= '0;
            bus.MemWrite  <= 1'b0;
            bus.ResultSrc <= '0;
            bus.Branch    <= 1'b0;
            bus.Jump      <= 1'b0;
            bus.funct3    <= '0;
            bus.pc_out    <= '0;
`ifdef DECODE_TRAP_EN
            bus.illegal   <= 1'b0;
`endif
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.rs1       <= dec_rs1;
            bus.rs2       <= dec_rs2;
            bus.rd        <= dec_rd;
            bus.RegWrite  <= reg_write && (dec_rd != '0);
            bus.ALUctrl   <= alu_op;
            bus.ALUSrc    <= alu_src;
            bus.ImmExt    <= imm_ext;
            bus.MemWrite  <= mem_write;
            bus.ResultSrc <= result_src;
            bus.Branch    <= branch;
            bus.Jump      <= jump;
            bus.funct3    <= f3;
            bus.pc_out    <= pc_d;
`ifdef DECODE_TRAP_EN
            bus.illegal   <= !legal;
`endif
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: fixed decode vectors, handshake corner sequences
// and a randomized run checked against a behavioural pipeline model.
module tb_decode_stage;
    import decode_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic [3:0]  alu;
        logic        alu_src;
        logic [31:0] imm;
        logic        mem_write;
        logic [1:0]  res;
        logic        branch;
        logic        jump;
        logic [2:0]  f3;
        logic        illegal;
    } pay_t;

    typedef struct {
        logic [31:0] instr;
        pay_t        exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pay_t mk(input int rs1, input int rs2, input int rd, input bit rw,
                                input alu_op_e alu, input bit src, input logic [31:0] imm,
                                input bit mw, input int res, input bit br, input bit j,
                                input int f3, input bit ill);
        pay_t p;
        p.rs1 = 5'(rs1); p.rs2 = 5'(rs2); p.rd = 5'(rd); p.reg_write = rw;
        p.alu = alu; p.alu_src = src; p.imm = imm; p.mem_write = mw;
        p.res = 2'(res); p.branch = br; p.jump = j; p.f3 = 3'(f3); p.illegal = ill;
        return p;
    endfunction

    function automatic pay_t vis(input pay_t p);
        pay_t q = p;
`ifndef DECODE_TRAP_EN
        q.illegal = 1'b0;
`endif
        return q;
    endfunction

    function automatic pay_t dut_pay();
        pay_t p;
        p.rs1 = bus.rs1; p.rs2 = bus.rs2; p.rd = bus.rd; p.reg_write = bus.RegWrite;
        p.alu = bus.ALUctrl; p.alu_src = bus.ALUSrc; p.imm = bus.ImmExt;
        p.mem_write = bus.MemWrite; p.res = bus.ResultSrc; p.branch = bus.Branch;
        p.jump = bus.Jump; p.f3 = bus.funct3;
`ifdef DECODE_TRAP_EN
        p.illegal = bus.illegal;
`else
        p.illegal = 1'b0;
`endif
        return p;
    endfunction

    // Reference decode: classify by instruction format, then build fields arithmetically
    function automatic pay_t ref_decode(input logic [31:0] w);
        pay_t p = '0;
        logic signed [31:0] s;
        logic [31:0] sgn, hi, imm;
        logic [2:0] f3;
        logic [6:0] f7;
        byte fmt;
        bit ok;
        alu_op_e alu_tab [8];
        alu_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        s = w; f3 = w[14:12]; f7 = w[31:25];
        sgn = (s < 0) ? 32'hFFFF_FFFF : 32'h0;
        fmt = "-"; ok = 0; imm = '0;
        case (w[6:0])
            7'h37, 7'h17: begin fmt = "U"; ok = 1; end
            7'h6F: begin fmt = "J"; ok = 1; end
            7'h67: begin fmt = "I"; ok = (f3 == 0); end
            7'h63: begin fmt = "B"; ok = (f3 != 2) && (f3 != 3); end
            7'h03: begin fmt = "I"; ok = (f3 != 3) && (f3 < 6); end
            7'h23: begin fmt = "S"; ok = (f3 < 3); end
            7'h13: begin
                fmt = "I";
                ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
            end
            7'h33: begin fmt = "R"; ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); end
            default: ok = 0;
        endcase
        p.f3 = f3;
        p.illegal = !ok;
        if (!ok) return p;
        if (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B") p.rs1 = w[19:15];
        if (fmt == "R" || fmt == "S" || fmt == "B") p.rs2 = w[24:20];
        if (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") p.rd = w[11:7];
        p.reg_write = (p.rd != 0);
        case (fmt)
            "I": begin hi = s >>> 20; imm = hi; end
            "S": begin hi = s >>> 25; imm = hi * 32 + 32'(w[11:7]); end
            "B": imm = sgn * 4096 + 32'(w[7]) * 2048 + 32'(w[30:25]) * 32 + 32'(w[11:8]) * 2;
            "U": imm = w & 32'hFFFF_F000;
            "J": imm = sgn * 1048576 + 32'(w[19:12]) * 4096 + 32'(w[20]) * 2048 + 32'(w[30:21]) * 2;
            default: imm = '0;
        endcase
        p.imm = imm;
        case (w[6:0])
            7'h37: begin p.alu = ALU_PASSB; p.alu_src = 1; end
            7'h17: p.alu_src = 1;
            7'h6F: begin p.jump = 1; p.res = 2; end
            7'h67: begin p.jump = 1; p.res = 2; p.alu_src = 1; end
            7'h63: begin p.branch = 1; p.alu = ALU_SUB; end
            7'h03: begin p.alu_src = 1; p.res = 1; end
            7'h23: begin p.alu_src = 1; p.mem_write = 1; end
            7'h13: begin
                p.alu_src = 1;
                p.alu = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : alu_tab[f3];
            end
            default: p.alu = (f7 == 7'h20) ? ((f3 == 0) ? ALU_SUB : ALU_SRA) : alu_tab[f3];
        endcase
        return p;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [6:0] ops [8];
        ops = '{7'h03, 7'h33, 7'h13, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h67};
        w = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            w[6:0]   = ops[$urandom_range(0, 7)];
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) w[31:25] = '0;
        end
        return w;
    endfunction

    vec_t vecs [13];

    bit          m_valid;
    pay_t        m_pay;
    logic [31:0] m_pc;

    initial begin
        vecs[0]  = '{32'hFFB00093, mk(0, 0, 1, 1, ALU_ADD,  1, 32'hFFFFFFFB, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{32'hFFDFF06F, mk(0, 0, 0, 0, ALU_ADD,  0, 32'hFFFFFFFC, 0, 2, 0, 1, 7, 0)};
        vecs[2]  = '{32'h00128333, mk(5, 1, 6, 1, ALU_ADD,  0, 32'h0,        0, 0, 0, 0, 0, 0)};
        vecs[3]  = '{32'h00012283, mk(2, 0, 5, 1, ALU_ADD,  1, 32'h0,        0, 1, 0, 0, 2, 0)};
        vecs[4]  = '{32'h00512423, mk(2, 5, 0, 0, ALU_ADD,  1, 32'h8,        1, 0, 0, 0, 2, 0)};
        vecs[5]  = '{32'hFE208CE3, mk(1, 2, 0, 0, ALU_SUB,  0, 32'hFFFFFFF8, 0, 0, 1, 0, 0, 0)};
        vecs[6]  = '{32'h123451B7, mk(0, 0, 3, 1, ALU_PASSB, 1, 32'h12345000, 0, 0, 0, 0, 5, 0)};
        vecs[7]  = '{32'h404183B3, mk(3, 4, 7, 1, ALU_SUB,  0, 32'h0,        0, 0, 0, 0, 0, 0)};
        vecs[8]  = '{32'h4034D493, mk(9, 0, 9, 1, ALU_SRA,  1, 32'h403,      0, 0, 0, 0, 5, 0)};
        vecs[9]  = '{32'h0000007F, mk(0, 0, 0, 0, ALU_ADD,  0, 32'h0,        0, 0, 0, 0, 0, 1)};
        vecs[10] = '{32'h004280E7, mk(5, 0, 1, 1, ALU_ADD,  1, 32'h4,        0, 2, 0, 1, 0, 0)};
        vecs[11] = '{32'h00208033, mk(1, 2, 0, 0, ALU_ADD,  0, 32'h0,        0, 0, 0, 0, 0, 0)};
        vecs[12] = '{32'h022081B3, mk(0, 0, 0, 0, ALU_ADD,  0, 32'h0,        0, 0, 0, 0, 0, 1)};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.instr = '0; bus.pc_in = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        tick(); tick();
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_payload", 64'(dut_pay()), 64'd0);
        chk("reset_pc", 64'(bus.pc_out), 64'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 13; i++) begin
            bus.in_valid = 1'b0; bus.out_ready = 1'b1;
            tick();
            bus.in_valid = 1'b1; bus.instr = vecs[i].instr; bus.pc_in = 32'h1000 + 32'(i * 4);
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("vec%0d_payload", i), 64'(vis(dut_pay())), 64'(vis(vecs[i].exp)));
            chk($sformatf("vec%0d_pc", i), 64'(bus.pc_out), 64'(32'h1000 + 32'(i * 4)));
        end

        // load-use: lw x5 then add x6,x5,x1
        tick();
        bus.in_valid = 1'b1; bus.instr = vecs[3].instr; bus.out_ready = 1'b1;
        tick();
        bus.instr = vecs[2].instr;
        #1;
        chk("hazard_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("hazard_bubble", 64'(bus.out_valid), 64'd0);
        chk("hazard_release", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("hazard_add_valid", 64'(bus.out_valid), 64'd1);
        chk("hazard_add_payload", 64'(vis(dut_pay())), 64'(vis(vecs[2].exp)));

        // downstream stall for three cycles
        tick();
        bus.in_valid = 1'b1; bus.instr = vecs[0].instr; bus.pc_in = 32'h200;
        tick();
        bus.instr = vecs[2].instr; bus.pc_in = 32'h204; bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", c), 64'(bus.in_ready), 64'd0);
            tick();
            chk($sformatf("stall%0d_valid", c), 64'(bus.out_valid), 64'd1);
            chk($sformatf("stall%0d_payload", c), 64'(vis(dut_pay())), 64'(vis(vecs[0].exp)));
            chk($sformatf("stall%0d_pc", c), 64'(bus.pc_out), 64'(32'h200));
        end
        bus.out_ready = 1'b1;
        #1;
        chk("stall_release_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("stall_next_payload", 64'(vis(dut_pay())), 64'(vis(vecs[2].exp)));
        chk("stall_next_pc", 64'(bus.pc_out), 64'(32'h204));

        // flush with beq in ID/EX and jal presented
        tick();
        bus.in_valid = 1'b1; bus.instr = vecs[5].instr;
        tick();
        bus.instr = vecs[1].instr; bus.flush = 1'b1; bus.out_ready = 1'b0;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("flush_jal_dropped", 64'(bus.out_valid), 64'd0);

        // reset mid-stream
        bus.in_valid = 1'b1; bus.instr = vecs[6].instr; bus.pc_in = 32'h300;
        tick();
        bus.in_valid = 1'b0;
        chk("midrst_pre_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_payload", 64'(dut_pay()), 64'd0);
        chk("midrst_pc", 64'(bus.pc_out), 64'd0);

        // randomized run against the pipeline model
        m_valid = 0; m_pay = '0; m_pc = '0;
        for (int n = 0; n < 3000; n++) begin
            bit   hz, exp_ready, acc;
            pay_t d;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.instr     = gen_instr();
            bus.pc_in     = $urandom;
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            d = ref_decode(bus.instr);
            hz = bus.in_valid && m_valid && (m_pay.res == 2'b01) && (m_pay.rd != 0) &&
                 ((d.rs1 == m_pay.rd) || (d.rs2 == m_pay.rd));
            exp_ready = !bus.flush && !hz && (!m_valid || bus.out_ready);
            acc = bus.in_valid && exp_ready;
            #1;
            chk($sformatf("rnd%0d_in_ready", n), 64'(bus.in_ready), 64'(exp_ready));
            tick();
            if (bus.flush) begin
                m_valid = 0;
            end else if (acc) begin
                m_valid = 1; m_pay = d; m_pc = bus.pc_in;
            end else if (bus.out_ready) begin
                m_valid = 0;
            end
            chk($sformatf("rnd%0d_out_valid", n), 64'(bus.out_valid), 64'(m_valid));
            if (m_valid) begin
                chk($sformatf("rnd%0d_payload", n), 64'(vis(dut_pay())), 64'(vis(m_pay)));
                chk($sformatf("rnd%0d_pc", n), 64'(bus.pc_out), 64'(m_pc));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
